// File: rtl/seq_carry_skip_adder.sv
// Multi-cycle carry-skip adder/subtractor: one BLOCK_SIZE-bit block per cycle,
// LSB block first, with a valid/ready handshake on both the input and the result side.
module seq_carry_skip_adder #(
    parameter int N          = 16,
    parameter int BLOCK_SIZE = 4,
    localparam int NB        = (N + BLOCK_SIZE - 1) / BLOCK_SIZE,
    localparam int SCW       = $clog2(NB + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           cin,
    input  logic           sub,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   sum,
    output logic           cout,
    output logic           overflow,
    output logic [SCW-1:0] skip_count
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
    // in_ready is high only in IDLE; out_valid holds with stable results until out_ready.

    localparam int KW     = (NB > 1) ? $clog2(NB) : 1;
    localparam int PW     = NB * BLOCK_SIZE;
    localparam int LAST_I = (N - 1) - (NB - 1) * BLOCK_SIZE;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic           c_q, c_d, cout_q, cout_d, ovf_q, ovf_d, out_valid_q, out_valid_d;
    logic [KW-1:0]  k_q, k_d;
    logic [SCW-1:0] skip_q, skip_d;

    logic [BLOCK_SIZE-1:0] a_blk, b_blk, v_blk, s_blk;
    logic [PW-1:0]         sum_pad;
    logic                  carry, all_p, c_msb, blk_cout, p;
    int                    shamt;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        k_d         = k_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        skip_d      = skip_q;
        out_valid_d = out_valid_q;
        shamt       = int'(k_q) * BLOCK_SIZE;
        a_blk       = BLOCK_SIZE'(PW'(a_q) >> shamt);
        b_blk       = BLOCK_SIZE'(PW'(b_q) >> shamt);
        // Marks the bits of the current block that exist (last block may be partial).
        v_blk       = BLOCK_SIZE'(PW'({N{1'b1}}) >> shamt);
        s_blk       = '0;
        carry       = c_q;
        all_p       = 1'b1;
        c_msb       = c_q;
        p           = 1'b0;
        blk_cout    = c_q;
        sum_pad     = PW'(sum_q);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    c_d     = sub ? ~cin : cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    skip_d  = '0;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < BLOCK_SIZE; i++) begin
                    p = a_blk[i] ^ b_blk[i];
                    if (i == LAST_I) c_msb = carry;
                    if (v_blk[i]) begin
                        s_blk[i] = p ^ carry;
                        carry    = (a_blk[i] & b_blk[i]) | (p & carry);
                        all_p    = all_p & p;
                    end
                end
                blk_cout = all_p ? c_q : carry;
                sum_pad  = (sum_pad & ~(PW'(v_blk) << shamt)) | (PW'(s_blk) << shamt);
                sum_d    = N'(sum_pad);
                c_d      = blk_cout;
                if (all_p) skip_d = skip_q + SCW'(1);
                if (int'(k_q) == NB - 1) begin
                    cout_d      = blk_cout;
                    ovf_d       = c_msb ^ blk_cout;
                    k_d         = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            k_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            skip_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            k_q         <= k_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            skip_q      <= skip_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign sum        = sum_q;
    assign cout       = cout_q;
    assign overflow   = ovf_q;
    assign skip_count = skip_q;

endmodule
